hilo_mult_sequencer: RTL and testbench

//  Multi-cycle sequencer for the ALUOp=4'b1111 class: mul, mult, multu, madd, msub.

---
 rtl/hilo_mult_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_hilo_mult_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_sequencer.sv
// HI/LO owner and radix-2 shift-add multiply sequencer beside the EX-stage ALU.
// Optional MUL_EARLY_TERM_EN: leave MUL once the remaining multiplier bits are zero.
module hilo_mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiLoRead,
    input  logic             Flush,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] MulResult,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FIX,
        S_ACC
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic             neg_q, neg_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mr_q, mr_d;
    logic             done_q, done_d;

    logic             is_mult;
    logic             is_signed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    fixed;
    logic [PW-1:0]    hilo;
    logic [PW-1:0]    acc_sum;
    logic [PW-1:0]    step;
    logic             last;

    assign is_mult   = (Op == OP_MULT) || (Op == OP_MULTU) ||
                       (Op == OP_MADD) || (Op == OP_MSUB) ||
                       (Op == OP_MUL);
    assign is_signed = (Op != OP_MULTU);
    assign a_mag     = (is_signed && A[WIDTH-1]) ? -A : A;
    assign b_mag     = (is_signed && B[WIDTH-1]) ? -B : B;
    assign fixed     = neg_q ? -prod_q : prod_q;
    assign hilo      = {hi_q, lo_q};
    assign acc_sum   = (op_q == OP_MSUB) ? hilo - prod_q : hilo + prod_q;
    assign step      = mplier_q[0] ? prod_q + mcand_q : prod_q;

`ifdef MUL_EARLY_TERM_EN
    assign last = (cnt_q == CW'(WIDTH - 1)) ||
                  (mplier_q[WIDTH-1:1] == '0);
`else
    assign last = (cnt_q == CW'(WIDTH - 1));
`endif

    // Next-state, datapath and HI/LO update; Flush overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mr_d     = mr_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (Op == OP_MTHI) begin
                        hi_d = A;
                    end else if (Op == OP_MTLO) begin
                        lo_d = A;
                    end else if (is_mult) begin
                        mcand_d  = {{WIDTH{1'b0}}, a_mag};
                        mplier_d = b_mag;
                        prod_d   = '0;
                        cnt_d    = '0;
                        neg_d    = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        op_d     = Op;
                        state_d  = S_MUL;
                    end
                end
            end
            S_MUL: begin
                prod_d   = step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if ((op_q == OP_MADD) || (op_q == OP_MSUB)) begin
                    prod_d  = fixed;
                    state_d = S_ACC;
                end else if (op_q == OP_MUL) begin
                    mr_d    = fixed[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    hi_d    = fixed[PW-1:WIDTH];
                    lo_d    = fixed[WIDTH-1:0];
                    mr_d    = fixed[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ACC: begin
                hi_d    = acc_sum[PW-1:WIDTH];
                lo_d    = acc_sum[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (Flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            mr_d    = mr_q;
            done_d  = 1'b0;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mr_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mr_q     <= mr_d;
            done_q   <= done_d;
        end
    end

    assign Busy      = (state_q != S_IDLE);
    assign Stall     = Busy & (Start | HiLoRead);
    assign Done      = done_q;
    assign MulResult = mr_q;
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Directed bench for hilo_mult_sequencer with a result scoreboard.
// Default build: fixed 32-cycle multiply loop.
module tb_hilo_mult_sequencer;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [2:0]   Op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         HiLoRead;
    logic         Flush;
    logic         Busy;
    logic         Stall;
    logic         Done;
    logic [W-1:0] MulResult;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] mr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi, m_lo, m_mr;
    int          errors = 0;
    int          checks = 0;

    hilo_mult_sequencer #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .HiLoRead  (HiLoRead),
        .Flush     (Flush),
        .Busy      (Busy),
        .Stall     (Stall),
        .Done      (Done),
        .MulResult (MulResult),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 Clk = ~Clk;

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mprod(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb2;
        if (op == 3'b001) begin
            return {32'b0, a} * {32'b0, b};
        end
        sa  = $signed(a);
        sb2 = $signed(b);
        return sa * sb2;
    endfunction

    task automatic model_push(input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b);
        logic [63:0] p, hl;
        p  = mprod(op, a, b);
        hl = {m_hi, m_lo};
        case (op)
            3'b000, 3'b001: begin
                hl   = p;
                m_mr = p[31:0];
            end
            3'b010: hl = hl + p;
            3'b011: hl = hl - p;
            3'b100: m_mr = p[31:0];
            default: ;
        endcase
        m_hi = hl[63:32];
        m_lo = hl[31:0];
        sb.push_back('{m_hi, m_lo, m_mr});
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_hi"}, HI, e.hi);
            chk({tag, "_lo"}, LO, e.lo);
            chk({tag, "_mr"}, MulResult, e.mr);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat);
        int n;
        model_push(op, a, b);
        Op = op;
        A = a;
        B = b;
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        chk({tag, "_busy"}, Busy, 1);
        n = 0;
        while (!Done && n < 100) begin
            cyc();
            n++;
        end
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_busy_done"}, Busy, 0);
        pop_cmp(tag);
        cyc();
        chk({tag, "_done_pulse"}, Done, 0);
    endtask

    task automatic mt(input string tag, input logic [2:0] op,
                      input logic [31:0] a);
        Op = op;
        A = a;
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        if (op == 3'b101) m_hi = a;
        if (op == 3'b110) m_lo = a;
        chk({tag, "_hi"}, HI, m_hi);
        chk({tag, "_lo"}, LO, m_lo);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_done"}, Done, 0);
    endtask

    initial begin
        int dn;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        Reset = 1'b0;
        Start = 1'b0;
        Flush = 1'b0;
        HiLoRead = 1'b0;
        Op = '0;
        A = '0;
        B = '0;
        m_hi = '0;
        m_lo = '0;
        m_mr = '0;
        cyc();
        cyc();
        HiLoRead = 1'b1;
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_stall", Stall, 0);
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_mr", MulResult, 0);
        HiLoRead = 1'b0;
        Reset = 1'b1;
        cyc();

        run_op("mult_neg", 3'b000, 32'hFFFFFFFD, 32'd7, 33);
        chk("mult_neg_hi_k", HI, 32'hFFFFFFFF);
        chk("mult_neg_lo_k", LO, 32'hFFFFFFEB);

        run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        chk("multu_hi_k", HI, 32'hFFFFFFFE);
        chk("multu_lo_k", LO, 32'h00000001);
        run_op("mul_6x7", 3'b100, 32'd6, 32'd7, 33);
        chk("mul_mr_k", MulResult, 32'd42);
        chk("mul_hi_keep", HI, 32'hFFFFFFFE);
        chk("mul_lo_keep", LO, 32'h00000001);

        mt("mthi", 3'b101, 32'd5);
        mt("mtlo", 3'b110, 32'd10);
        run_op("madd", 3'b010, 32'd2, 32'd3, 34);
        chk("madd_hi_k", HI, 32'd5);
        chk("madd_lo_k", LO, 32'd16);
        run_op("msub", 3'b011, 32'd2, 32'd3, 34);
        chk("msub_hi_k", HI, 32'd5);
        chk("msub_lo_k", LO, 32'd10);

        run_op("mult_minmin", 3'b000, 32'h80000000, 32'h80000000, 33);
        run_op("madd_neg", 3'b010, 32'hFFFFFFFF, 32'd5, 34);
        run_op("msub_neg", 3'b011, 32'd7, 32'hFFFFFFF0, 34);
        run_op("mul_neg", 3'b100, 32'hFFFFFFFE, 32'd3, 33);
        chk("mul_neg_mr_k", MulResult, 32'hFFFFFFFA);
        run_op("multu_big", 3'b001, 32'h80000000, 32'd2, 33);
        for (int i = 0; i < 4; i++) begin
            rop = 3'($urandom_range(0, 4));
            ra = $urandom;
            rb = $urandom;
            run_op("rand", rop, ra, rb,
                   (rop == 3'b010 || rop == 3'b011) ? 34 : 33);
        end

        model_push(3'b000, 32'd9, 32'hFFFFFFF9);
        Op = 3'b000;
        A = 32'd9;
        B = 32'hFFFFFFF9;
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            cyc();
            chk("stl_busy", Busy, 64'(k < 33));
            chk("stl_done", Done, 64'(k == 33));
            HiLoRead = (k >= 5);
            Start = (k >= 10 && k <= 12);
            Op = Start ? 3'b101 : 3'b000;
            A = 32'hDEAD;
            #1;
            chk("stl_stall", Stall, 64'(k < 33 && k >= 5));
        end
        pop_cmp("stl");
        HiLoRead = 1'b0;
        Start = 1'b1;
        Op = 3'b110;
        A = 32'h77;
        #1;
        chk("b2b_stall", Stall, 0);
        cyc();
        Start = 1'b0;
        m_lo = 32'h77;
        chk("b2b_lo", LO, 32'h77);
        chk("b2b_hi", HI, m_hi);
        chk("b2b_busy", Busy, 0);

        run_op("pre_flush", 3'b000, 32'd3, 32'd4, 33);
        Op = 3'b000;
        A = 32'd100;
        B = 32'd200;
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        repeat (9) cyc();
        Flush = 1'b1;
        cyc();
        Flush = 1'b0;
        chk("fl_busy", Busy, 0);
        chk("fl_hi", HI, m_hi);
        chk("fl_lo", LO, m_lo);
        chk("fl_mr", MulResult, m_mr);
        dn = 0;
        repeat (40) begin
            cyc();
            if (Done) dn++;
        end
        chk("fl_no_done", dn, 0);
        chk("fl_lo_late", LO, m_lo);
        Op = 3'b101;
        A = 32'h1234;
        Start = 1'b1;
        Flush = 1'b1;
        cyc();
        Start = 1'b0;
        Flush = 1'b0;
        chk("fl_idle_hi", HI, m_hi);
        chk("fl_idle_busy", Busy, 0);
        run_op("post_flush", 3'b000, 32'd3, 32'd4, 33);

        Op = 3'b000;
        A = 32'd11;
        B = 32'd13;
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        repeat (9) cyc();
        Reset = 1'b0;
        #1;
        chk("ar_busy", Busy, 0);
        chk("ar_hi", HI, 0);
        chk("ar_lo", LO, 0);
        chk("ar_mr", MulResult, 0);
        cyc();
        Reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        m_mr = '0;
        cyc();
        chk("ar_idle", Busy, 0);

        Op = 3'b111;
        A = 32'h55;
        B = 32'h66;
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        chk("undef_busy", Busy, 0);
        chk("undef_hi", HI, 0);
        chk("undef_lo", LO, 0);
        cyc();
        chk("undef_done", Done, 0);
        run_op("madd_after", 3'b010, 32'd4, 32'd5, 34);
        chk("madd_after_lo_k", LO, 32'd20);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
